i2c_adc_responder: RTL and testbench

I2C_ADC_RESPONDER -- requirements
Module: i2c_adc_responder

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_bus_sync.sv | 53 +++++
 rtl/i2c_adc_responder.sv | 185 ++++++++++++++++++
 tb/tb_i2c_adc_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Types and constants shared by the I2C ADC responder and the ADC master controller.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StIgnore
  } i2c_state_e;

  localparam logic [6:0] I2cDefaultAddr = 7'h28;
  localparam int unsigned BitCntW = 4;

  // Read image: byte 0 = {00, ch, data[11:8]}, byte 1 = data[7:0].
  function automatic logic [15:0] rd_snapshot(input logic [1:0] ch, input logic [11:0] data);
    return {2'b00, ch, data};
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for SCL/SDA plus SCL edge and START/STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic scl_meta_d, scl_sync_d, scl_prev_d;
  logic sda_meta_d, sda_sync_d, sda_prev_d;

  always_comb begin
    scl_meta_d = scl;
    scl_sync_d = scl_meta_q;
    scl_prev_d = scl_sync_q;
    sda_meta_d = sda_in;
    sda_sync_d = sda_meta_q;
    sda_prev_d = sda_sync_q;
  end

  // Reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_s     = sda_sync_q;
  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

endmodule

// File: rtl/i2c_adc_responder.sv
// I2C target: write bytes update config_reg; reads return a 16-bit channel/sample snapshot.
module i2c_adc_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = I2cDefaultAddr,
  parameter logic [7:0] CFG_RESET = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] sample_data,
  input  logic [1:0]  sample_ch,
  output logic [7:0]  config_reg,
  output logic        config_wr,
  output logic        read_done,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e         state_q, state_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]         rx_sr_q, rx_sr_d;
  logic [15:0]        rd_sr_q, rd_sr_d;
  logic               byte_idx_q, byte_idx_d;
  logic               sda_oe_q, sda_oe_d;
  logic [7:0]         config_q, config_d;
  logic               config_wr_q, config_wr_d;
  logic               read_done_q, read_done_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    rd_sr_d     = rd_sr_q;
    byte_idx_d  = byte_idx_q;
    sda_oe_d    = sda_oe_q;
    config_d    = config_q;
    config_wr_d = 1'b0;
    read_done_d = 1'b0;
    busy_d      = busy_q;

    if (stop_det) begin
      state_d   = StIdle;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = StAddr;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        StAddr, StWrByte: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            rx_sr_d   = {rx_sr_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (state_q == StWrByte) begin
              state_d  = StWrAck;
              sda_oe_d = 1'b1;
            end else if (rx_sr_q[7:1] == DEV_ADDR) begin
              state_d  = StAddrAck;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StAddrAck: begin
          if (scl_rise && rx_sr_q[0]) begin
            rd_sr_d    = rd_snapshot(sample_ch, sample_data);
            byte_idx_d = 1'b0;
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (rx_sr_q[0]) begin
              state_d  = StRdByte;
              sda_oe_d = ~rd_sr_q[15];
            end else begin
              state_d  = StWrByte;
              sda_oe_d = 1'b0;
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            state_d     = StWrByte;
            sda_oe_d    = 1'b0;
            config_d    = rx_sr_q;
            config_wr_d = 1'b1;
          end
        end
        StRdByte: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            // Shift after every bit so byte 1's MSB sits at [15] once byte 0 is out.
            rd_sr_d = {rd_sr_q[14:0], 1'b0};
            if (bit_cnt_q == 4'd8) begin
              state_d   = StRdAck;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else begin
              sda_oe_d = ~rd_sr_q[14];
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            read_done_d = byte_idx_q;
            if (sda_s) begin
              state_d = StIgnore;
            end else begin
              if (byte_idx_q) begin
                rd_sr_d = rd_snapshot(sample_ch, sample_data);
              end
              byte_idx_d = ~byte_idx_q;
            end
          end else if (scl_fall) begin
            state_d   = StRdByte;
            sda_oe_d  = ~rd_sr_q[15];
            bit_cnt_d = '0;
          end
        end
        StIdle, StIgnore: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      rd_sr_q     <= '0;
      byte_idx_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      config_q    <= CFG_RESET;
      config_wr_q <= 1'b0;
      read_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      rd_sr_q     <= rd_sr_d;
      byte_idx_q  <= byte_idx_d;
      sda_oe_q    <= sda_oe_d;
      config_q    <= config_d;
      config_wr_q <= config_wr_d;
      read_done_q <= read_done_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign config_reg = config_q;
  assign config_wr  = config_wr_q;
  assign read_done  = read_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_adc_responder.sv
// Directed bench: bit-banged I2C master driving a wired-AND SDA against the responder.
module tb_i2c_adc_responder;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        sda_m;
  logic        sda_in;
  logic        sda_oe;
  logic [11:0] sample_data;
  logic [1:0]  sample_ch;
  logic [7:0]  config_reg;
  logic        config_wr;
  logic        read_done;
  logic        busy;

  assign sda_in = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_adc_responder dut (
    .clk         (clk),
    .rst         (rst),
    .scl         (scl),
    .sda_in      (sda_in),
    .sda_oe      (sda_oe),
    .sample_data (sample_data),
    .sample_ch   (sample_ch),
    .config_reg  (config_reg),
    .config_wr   (config_wr),
    .read_done   (read_done),
    .busy        (busy)
  );

  int wr_cnt = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;
  always @(posedge clk) begin
    if (config_wr) wr_cnt <= wr_cnt + 1;
    if (read_done) rd_cnt <= rd_cnt + 1;
    if (sda_oe)    oe_cnt <= oe_cnt + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic bit_xfer(input logic b, output logic seen);
    sda_m = b;    wait_q();
    scl   = 1'b1; wait_q();
    seen  = sda_in;
    wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, s);
      d = {d[6:0], s};
    end
    bit_xfer(~mack, s);
  endtask

  typedef struct {
    logic        is_read;
    logic [7:0]  addr_byte;
    logic [7:0]  wdata;
    logic [1:0]  ch;
    logic [11:0] sdata;
    logic        exp_ack;
    logic [7:0]  exp_cfg;
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
    logic [1:0]  exp_wr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       ack, s;
    logic [7:0] b0, b1, b2;
    int         w0, r0, o0;

    vecs[0] = '{1'b0, 8'h50, 8'h10, 2'd0, 12'h000, 1'b1, 8'h10, 8'h00, 8'h00, 2'd1};
    vecs[1] = '{1'b0, 8'h50, 8'hA5, 2'd0, 12'h000, 1'b1, 8'hA5, 8'h00, 8'h00, 2'd1};
    vecs[2] = '{1'b1, 8'h51, 8'h00, 2'd2, 12'hABC, 1'b1, 8'hA5, 8'h2A, 8'hBC, 2'd0};
    vecs[3] = '{1'b1, 8'h51, 8'h00, 2'd3, 12'h5F0, 1'b1, 8'hA5, 8'h35, 8'hF0, 2'd0};
    vecs[4] = '{1'b1, 8'h51, 8'h00, 2'd0, 12'h123, 1'b1, 8'hA5, 8'h01, 8'h23, 2'd0};
    vecs[5] = '{1'b0, 8'h52, 8'h3C, 2'd0, 12'h000, 1'b0, 8'hA5, 8'h00, 8'h00, 2'd0};
    vecs[6] = '{1'b0, 8'h50, 8'h10, 2'd0, 12'h000, 1'b1, 8'h10, 8'h00, 8'h00, 2'd1};

    rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
    sample_data = '0; sample_ch = '0;
    repeat (3) @(negedge clk);
    check("rst_sda_oe", 16'(sda_oe), 16'h0);
    check("rst_config_reg", 16'(config_reg), 16'h10);
    check("rst_config_wr", 16'(config_wr), 16'h0);
    check("rst_read_done", 16'(read_done), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    rst = 1'b0;
    wait_q();

    for (int i = 0; i < 7; i++) begin
      sample_ch = vecs[i].ch; sample_data = vecs[i].sdata;
      w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cnt;
      i2c_start();
      write_byte(vecs[i].addr_byte, ack);
      check($sformatf("v%0d_addr_ack", i), 16'(ack), 16'(vecs[i].exp_ack));
      if (vecs[i].is_read) begin
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        check($sformatf("v%0d_byte0", i), 16'(b0), 16'(vecs[i].exp_b0));
        check($sformatf("v%0d_byte1", i), 16'(b1), 16'(vecs[i].exp_b1));
        check($sformatf("v%0d_read_done", i), 16'(rd_cnt - r0), 16'h1);
      end else begin
        write_byte(vecs[i].wdata, ack);
        check($sformatf("v%0d_data_ack", i), 16'(ack), 16'(vecs[i].exp_ack));
      end
      check($sformatf("v%0d_busy", i), 16'(busy), 16'(vecs[i].exp_ack));
      if (!vecs[i].exp_ack) check($sformatf("v%0d_oe_quiet", i), 16'(oe_cnt - o0), 16'h0);
      i2c_stop();
      check($sformatf("v%0d_busy_after_stop", i), 16'(busy), 16'h0);
      check($sformatf("v%0d_config_reg", i), 16'(config_reg), 16'(vecs[i].exp_cfg));
      check($sformatf("v%0d_config_wr", i), 16'(wr_cnt - w0), 16'(vecs[i].exp_wr));
    end

    // Multi-byte write: each byte overwrites config_reg.
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h50, ack);
    write_byte(8'h11, ack);
    check("mb_first_byte", 16'(config_reg), 16'h11);
    write_byte(8'h22, ack);
    check("mb_second_ack", 16'(ack), 16'h1);
    i2c_stop();
    check("mb_config_reg", 16'(config_reg), 16'h22);
    check("mb_config_wr", 16'(wr_cnt - w0), 16'h2);

    // Write then repeated START into a read, no STOP between.
    sample_ch = 2'd2; sample_data = 12'hABC;
    r0 = rd_cnt;
    i2c_start();
    write_byte(8'h50, ack);
    write_byte(8'h10, ack);
    check("sr_wr_ack", 16'(ack), 16'h1);
    i2c_start();
    write_byte(8'h51, ack);
    check("sr_rd_addr_ack", 16'(ack), 16'h1);
    read_byte(1'b1, b0);
    read_byte(1'b0, b1);
    i2c_stop();
    check("sr_config_reg", 16'(config_reg), 16'h10);
    check("sr_byte0", 16'(b0), 16'h2A);
    check("sr_byte1", 16'(b1), 16'hBC);
    check("sr_read_done", 16'(rd_cnt - r0), 16'h1);

    // Sample changes mid-byte 0; ACK after byte 1 rolls over to a fresh snapshot.
    sample_ch = 2'd0; sample_data = 12'h123;
    r0 = rd_cnt;
    i2c_start();
    write_byte(8'h51, ack);
    b0 = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) sample_data = 12'h456;
      bit_xfer(1'b1, s);
      b0 = {b0[6:0], s};
    end
    bit_xfer(1'b0, s);
    read_byte(1'b1, b1);
    read_byte(1'b0, b2);
    i2c_stop();
    check("chg_byte0", 16'(b0), 16'h01);
    check("chg_byte1", 16'(b1), 16'h23);
    check("chg_fresh_byte0", 16'(b2), 16'h04);
    check("chg_read_done", 16'(rd_cnt - r0), 16'h1);

    // Reset while driving a read bit low.
    i2c_start();
    write_byte(8'h50, ack);
    write_byte(8'h5A, ack);
    i2c_stop();
    check("pre_rst_config", 16'(config_reg), 16'h5A);
    sample_ch = 2'd0; sample_data = 12'h123;
    i2c_start();
    write_byte(8'h51, ack);
    check("rd_drive_low", 16'(sda_oe), 16'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_sda_oe", 16'(sda_oe), 16'h0);
    check("async_rst_config", 16'(config_reg), 16'h10);
    check("async_rst_busy", 16'(busy), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_q();
    i2c_start();
    write_byte(8'h50, ack);
    check("post_rst_addr_ack", 16'(ack), 16'h1);
    write_byte(8'h77, ack);
    i2c_stop();
    check("post_rst_config", 16'(config_reg), 16'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
